rfunc_round_ctrl: RTL

RFUNC_ROUND_CTRL -- requirements
Module: rfunc_round_ctrl

---
 rtl/rfunc_pkg.sv | 26 ++
 rtl/rfunc_bill.sv | 32 +++
 rtl/rfunc_round_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/rfunc_pkg.sv
// rfunc_pkg: shared definitions for the round controller.
//   - state_e     : controller FSM encoding (IDLE / RUN / DONE)
//   - SEL_*       : select codes of the round function (x[50:48])
//   - RW_DEFAULT  : default width of the round count
package rfunc_pkg;

  localparam int RW_DEFAULT = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Round-function select codes; codes 2..6 form one family that XORs
  // the low state byte into byte position (code-1).
  localparam logic [2:0] SEL_PASS  = 3'd0;
  localparam logic [2:0] SEL_SHXOR = 3'd1;
  localparam logic [2:0] SEL_BYTE1 = 3'd2;
  localparam logic [2:0] SEL_BYTE2 = 3'd3;
  localparam logic [2:0] SEL_BYTE3 = 3'd4;
  localparam logic [2:0] SEL_BYTE4 = 3'd5;
  localparam logic [2:0] SEL_BYTE5 = 3'd6;
  localparam logic [2:0] SEL_SHIFT = 3'd7;

endpackage

// File: rtl/rfunc_bill.sv
// rfunc_bill: combinational round function R.
//   x [55:0] : {key byte, 48-bit state}; x[50:48] selects the operation
//   y [47:0] : next state
module rfunc_bill
  import rfunc_pkg::*;
(
  input  logic [55:0] x,
  output logic [47:0] y
);

  logic [2:0]  sel;
  logic [47:0] lo;

  assign sel = x[50:48];
  assign lo  = {40'h0, x[7:0]};

  always_comb begin
    y = x[47:0];
    case (sel)
      SEL_PASS:  y = x[47:0];
      SEL_SHXOR: y = x[55:8] ^ lo;
      SEL_BYTE1: y = x[47:0] ^ (lo << 8);
      SEL_BYTE2: y = x[47:0] ^ (lo << 16);
      SEL_BYTE3: y = x[47:0] ^ (lo << 24);
      SEL_BYTE4: y = x[47:0] ^ (lo << 32);
      SEL_BYTE5: y = x[47:0] ^ (lo << 40);
      SEL_SHIFT: y = x[55:8];
      default:   y = x[47:0];
    endcase
  end

endmodule

// File: rtl/rfunc_round_ctrl.sv
// rfunc_round_ctrl: iterates the round function R over a 48-bit state,
// one round per cycle, keyed by a rotating 8-byte key.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : job handshake (accepted only in IDLE)
//   in_data/in_key       : initial state S0 and 8 round-key bytes
//   in_rounds            : round count N (0 goes straight to DONE)
//   abort                : drop the job in RUN or DONE
//   out_valid/out_ready  : result handshake (held in DONE)
//   out_data             : final state, straight from the S register
//   busy                 : high in RUN or DONE
//   round_cnt            : rounds completed for the current job
module rfunc_round_ctrl
  import rfunc_pkg::*;
#(
  parameter int RW = RW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [47:0]   in_data,
  input  logic [63:0]   in_key,
  input  logic [RW-1:0] in_rounds,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [47:0]   out_data,
  output logic          busy,
  output logic [RW-1:0] round_cnt
);

  state_e        state_q, state_d;
  logic [47:0]   s_q, s_d;
  logic [63:0]   k_q, k_d;
  logic [RW-1:0] n_q, n_d;
  logic [RW-1:0] cnt_q, cnt_d;

  logic [7:0]    key_byte;
  logic [47:0]   r_out;

  // Key bytes are consumed cyclically: byte index = round_cnt mod 8.
  assign key_byte = k_q[{cnt_q[2:0], 3'b000} +: 8];

  rfunc_bill u_rfunc (
    .x ({key_byte, s_q}),
    .y (r_out)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          s_d     = in_data;
          k_d     = in_key;
          n_d     = in_rounds;
          cnt_d   = '0;
          state_d = (in_rounds == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          s_d   = r_out;
          cnt_d = cnt_q + 1'b1;
          // n_q >= 1 here, so cnt never wraps before reaching n_q.
          if (cnt_d == n_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // abort and out_ready both return to IDLE; the result is simply
        // not presented again either way.
        if (abort || out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_data  = s_q;
  assign round_cnt = cnt_q;

endmodule
